// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream DMA arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCKED)
//   tid_w(n)    : width of a source index, max(1, $clog2(n))
//   CNT_W       : width of the optional per-packet beat counter
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned tid_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_dma_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  : per-source request vector
//   last : index of the most recently served source
//   any  : at least one request is present
//   idx  : first requester searching upward from last+1, wrapping
module rr_pick #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned TID_W = 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [TID_W-1:0] last,
    output logic             any,
    output logic [TID_W-1:0] idx
);

    logic             hit_hi;
    logic [TID_W-1:0] idx_hi;
    logic [TID_W-1:0] idx_lo;

    // Lowest requester above 'last' wins; otherwise the lowest at or below it.
    always_comb begin
        hit_hi = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hit_hi = 1'b1;
                    idx_hi = TID_W'(i);
                end else begin
                    idx_lo = TID_W'(i);
                end
            end
        end
        any = |req;
        idx = hit_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/axis_dma_arbiter.sv
// Round-robin, packet-locked arbiter sharing one AXI-Stream master between
// N_SRC sources. A grant is held from the first beat to the TLAST beat; each
// output beat carries its source index on m_axis_tid. Output is registered.
// Optional build macro ARB_MAX_BEATS_EN limits packets to MAX_BEATS beats,
// forcing TLAST and raising sticky err_trunc when a packet is cut.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   s_axis_tvalid/tdata/tlast/tready : per-source slave streams
//   m_axis_tvalid/tdata/tlast/tid/tready : shared master stream
//   err_trunc              : sticky truncation flag (0 without the macro)
module axis_dma_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC-1:0]              s_axis_tvalid,
    input  logic [N_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]              s_axis_tlast,
    output logic [N_SRC-1:0]              s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [tid_w(N_SRC)-1:0]       m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          err_trunc
);

    localparam int unsigned TID_W = tid_w(N_SRC);

    arb_state_e       state, state_d;
    logic [TID_W-1:0] grant, grant_d;
    logic [TID_W-1:0] last_grant, last_grant_d;

    logic                  pick_any;
    logic [TID_W-1:0]      pick_idx;
    logic                  src_valid;
    logic                  src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  out_free;
    logic                  src_hs;
    logic                  at_limit;

    rr_pick #(
        .N_SRC (N_SRC),
        .TID_W (TID_W)
    ) u_pick (
        .req  (s_axis_tvalid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Granted source's beat.
    assign src_valid = s_axis_tvalid[grant];
    assign src_last  = s_axis_tlast[grant];
    assign src_data  = s_axis_tdata[32'(grant) * DATA_WIDTH +: DATA_WIDTH];

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    // Next-state and source-ready logic.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        last_grant_d  = last_grant;
        s_axis_tready = '0;
        src_hs        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                s_axis_tready[grant] = out_free;
                src_hs               = src_valid && out_free;
                if (src_hs && (src_last || at_limit)) begin
                    last_grant_d = grant;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= TID_W'(N_SRC - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            if (src_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= src_data;
                m_axis_tlast  <= src_last || at_limit;
                m_axis_tid    <= grant;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef ARB_MAX_BEATS_EN
    logic [CNT_W-1:0] beat_cnt;
    logic             err_q;

    // Counter holds the number of beats already accepted in this grant.
    assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign err_trunc = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && pick_any) begin
                beat_cnt <= '0;
            end else if (src_hs) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (src_hs && !src_last && at_limit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_max_beats;

    assign at_limit         = 1'b0;
    assign err_trunc        = 1'b0;
    assign unused_max_beats = ^CNT_W'(MAX_BEATS);
`endif

endmodule

// File: tb/tb_axis_dma_arbiter.sv
// Self-checking bench for axis_dma_arbiter: per-source packet queues drive the
// slaves, a packet-level round-robin model predicts the output beat sequence.
module tb_axis_dma_arbiter;

    localparam int N      = 2;
    localparam int DW     = 32;
    localparam int TW     = (N <= 2) ? 1 : $clog2(N);
    localparam int MAXB_P = 4;
`ifdef ARB_MAX_BEATS_EN
    localparam int MAXB = MAXB_P;
`else
    localparam int MAXB = 0;
`endif
    localparam int MAXB_MOD = (MAXB == 0) ? 1 : MAXB;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } sbeat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [TW-1:0] tid;
    } mbeat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_axis_tvalid = '0;
    logic [N*DW-1:0]   s_axis_tdata = '0;
    logic [N-1:0]      s_axis_tlast = '0;
    logic [N-1:0]      s_axis_tready;
    logic              m_axis_tvalid;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
    logic [TW-1:0]     m_axis_tid;
    logic              m_axis_tready = 1'b1;
    logic              err_trunc;

    always #5 clk = ~clk;

    axis_dma_arbiter #(
        .N_SRC      (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB_P)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tready (m_axis_tready),
        .err_trunc     (err_trunc)
    );

    sbeat_t srcq [N][$];
    mbeat_t expq [$];
    int     pos [N];
    int     model_last = N - 1;
    bit     exp_err = 1'b0;
    int     total = 0;
    int     bad = 0;
    int     fs, fm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base,
                           input logic [DW-1:0] step, input bit rnd);
        sbeat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = rnd ? DW'($urandom) : base + step * DW'(j);
            b.last = (j == len - 1);
            srcq[src].push_back(b);
        end
    endtask

    // Packet-level round robin: every source with pending beats requests at
    // each arbitration; a grant lasts until tlast or MAXB beats (if limited).
    function automatic void build_expected();
        sbeat_t q [N][$];
        sbeat_t b;
        mbeat_t m;
        int     s, c, cnt;
        bit     done, busy;
        for (int i = 0; i < N; i++) q[i] = srcq[i];
        busy = 1'b1;
        while (busy) begin
            s = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_last + k) % N;
                if (s < 0 && q[c].size() > 0) s = c;
            end
            if (s < 0) begin
                busy = 1'b0;
            end else begin
                cnt  = 0;
                done = 1'b0;
                while (!done) begin
                    b = q[s].pop_front();
                    cnt++;
                    m.data = b.data;
                    m.last = b.last || (MAXB != 0 && cnt == MAXB);
                    m.tid  = TW'(s);
                    if (m.last && !b.last) exp_err = 1'b1;
                    expq.push_back(m);
                    done = m.last || (q[s].size() == 0);
                end
                model_last = s;
            end
        end
    endfunction

    // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1.
    task automatic run(input int mode, input int gap_pct, input int budget, input int stop_m,
                       output int first_s, output int first_m);
        logic [N-1:0]    tv, tl, shs;
        logic [N*DW-1:0] td;
        mbeat_t          e;
        bit              held, mhs;
        logic [DW+TW:0]  held_val;
        int              cyc, mcount;
        bit              gap_ok;
        build_expected();
        for (int i = 0; i < N; i++) pos[i] = 0;
        cyc = 0; mcount = 0; first_s = -1; first_m = -1; held = 1'b0; held_val = '0;
        while (expq.size() > 0 && cyc < budget && (stop_m == 0 || mcount < stop_m)) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                gap_ok = (pos[i] > 0) && (MAXB == 0 || (pos[i] % MAXB_MOD) != 0);
                td[i*DW +: DW] = DW'($urandom);
                tl[i] = 1'($urandom_range(1));
                tv[i] = 1'b0;
                if (srcq[i].size() > 0 && !(gap_ok && $urandom_range(99) < gap_pct)) begin
                    tv[i] = 1'b1;
                    td[i*DW +: DW] = srcq[i][0].data;
                    tl[i] = srcq[i][0].last;
                end
            end
            s_axis_tvalid = tv;
            s_axis_tdata  = td;
            s_axis_tlast  = tl;
            case (mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(1));
                default: m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            #1;
            if (held) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
                chk("hold_beat", 64'({m_axis_tdata, m_axis_tlast, m_axis_tid}), 64'(held_val));
            end
            held     = m_axis_tvalid && !m_axis_tready;
            held_val = {m_axis_tdata, m_axis_tlast, m_axis_tid};
            shs      = s_axis_tvalid & s_axis_tready;
            mhs      = m_axis_tvalid && m_axis_tready;
            if (mhs) begin
                mcount++;
                if (first_m < 0) first_m = cyc;
                if (expq.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    chk("beat_tid", 64'(m_axis_tid), 64'(e.tid));
                end
            end
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (shs[i]) begin
                    if (first_s < 0) first_s = cyc;
                    pos[i] = srcq[i][0].last ? 0 : pos[i] + 1;
                    void'(srcq[i].pop_front());
                end
            end
            cyc++;
        end
        if (stop_m == 0) begin
            chk("drained", 64'(expq.size()), 64'd0);
            @(negedge clk);
            s_axis_tvalid = '0;
            m_axis_tready = 1'b1;
            repeat (2) @(negedge clk);
            #1;
            chk("idle_valid", 64'(m_axis_tvalid), 64'd0);
            chk("err_trunc", 64'(err_trunc), 64'(exp_err));
        end else begin
            chk("stop_reached", 64'(mcount), 64'(stop_m));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({tag, "_m_tid"}, 64'(m_axis_tid), 64'd0);
        chk({tag, "_err"}, 64'(err_trunc), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n         = 1'b0;
        s_axis_tvalid = '1;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset(tag);
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        model_last = N - 1;
        exp_err    = 1'b0;
        @(negedge clk);
        s_axis_tvalid = '0;
        rst_n         = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Power-on reset with sources requesting: nothing may be accepted.
        do_reset("por");

        // Single source, 4 beats, one arbitration cycle before the first beat.
        add_pkt(0, 4, 32'h11, 32'h11, 1'b0);
        run(0, 0, 200, 0, fs, fm);
        chk("t1_first_src_hs", 64'(fs), 64'd1);
        chk("t1_first_m_hs", 64'(fm), 64'd2);

        // Reset after two output beats of a 4-beat packet.
        add_pkt(0, 4, 32'h50, 32'h1, 1'b0);
        run(2, 0, 200, 2, fs, fm);
        do_reset("mid");

        // Two sources, two rounds of 3-beat packets: A, B, A, B.
        add_pkt(0, 3, 32'hA0, 32'h1, 1'b0);
        add_pkt(1, 3, 32'hB0, 32'h1, 1'b0);
        add_pkt(0, 3, 32'hA8, 32'h1, 1'b0);
        add_pkt(1, 3, 32'hB8, 32'h1, 1'b0);
        run(0, 0, 400, 0, fs, fm);
        chk("t2_first_tid_src0", 64'(fs), 64'd1);

        // Output stalls 1,0,0,1 with random data.
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, int'($urandom_range(1, 6)), '0, '0, 1'b1);
            add_pkt(1, int'($urandom_range(1, 6)), '0, '0, 1'b1);
        end
        run(2, 0, 2000, 0, fs, fm);

        // Granted source drops tvalid mid-packet while the other waits.
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, int'($urandom_range(3, 7)), '0, '0, 1'b1);
            add_pkt(1, int'($urandom_range(3, 7)), '0, '0, 1'b1);
        end
        run(0, 50, 2000, 0, fs, fm);

        // Random ready, random gaps, random lengths.
        for (int p = 0; p < 6; p++) begin
            add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(1, 7)), '0, '0, 1'b1);
        end
        run(1, 25, 3000, 0, fs, fm);

`ifdef ARB_MAX_BEATS_EN
        // 6-beat packet cut to 4 + 2, other source served in between.
        do_reset("pre_trunc");
        add_pkt(0, 6, 32'hC0, 32'h1, 1'b0);
        add_pkt(1, 2, 32'hD0, 32'h1, 1'b0);
        run(0, 0, 400, 0, fs, fm);
        chk("trunc_err_set", 64'(err_trunc), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
